// File: rtl/imm_packer_pkg.sv
// Shared immediate-format codes and error codes.
// Used by both the immediate extender and the packer.
package imm_packer_pkg;

    typedef enum logic [2:0] {
        IMM_I        = 3'b000,
        IMM_S        = 3'b001,
        IMM_B        = 3'b010,
        IMM_J        = 3'b011,
        IMM_U        = 3'b100,
        IMM_SHAMT    = 3'b101,
        IMM_NONE     = 3'b110,
        IMM_NONE_ALT = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10
    } imm_err_e;

    typedef struct packed {
        imm_src_e    src;
        logic [31:0] imm;
        logic [31:0] tmpl;
    } beat_t;

    typedef struct packed {
        beat_t    beat;
        imm_err_e err;
    } chk_beat_t;

    // True when v is representable as an nbits-wide signed value.
    function automatic logic fits_signed(
        input logic [31:0] v,
        input int unsigned nbits
    );
        logic signed [31:0] sh;
        sh = $signed(v) >>> (nbits - 1);
        return (sh == 32'sd0) || (sh == -32'sd1);
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Scatters immediate bits into an instruction template.
// Purely combinational; the type's fields are cleared first.
module imm_field_pack
    import imm_packer_pkg::*;
(
    input  imm_src_e    src_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] tmpl_i,
    output logic [31:0] insn_o
);

    logic [31:0] mask;
    logic [31:0] bits;

    // Select the field mask and the scattered immediate per type.
    always_comb begin
        mask = '0;
        bits = '0;
        unique case (src_i)
            IMM_I: begin
                mask = 32'hFFF0_0000;
                bits = {imm_i[11:0], 20'b0};
            end
            IMM_S: begin
                mask = 32'hFE00_0F80;
                bits = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
            end
            IMM_B: begin
                mask = 32'hFE00_0F80;
                bits = {imm_i[12], imm_i[10:5], 13'b0,
                        imm_i[4:1], imm_i[11], 7'b0};
            end
            IMM_J: begin
                mask = 32'hFFFF_F000;
                bits = {imm_i[20], imm_i[10:1], imm_i[11],
                        imm_i[19:12], 12'b0};
            end
            IMM_U: begin
                mask = 32'hFFFF_F000;
                bits = {imm_i[31:12], 12'b0};
            end
            IMM_SHAMT: begin
                // funct7 in [31:25] stays from the template (SRAI)
                mask = 32'h01F0_0000;
                bits = {7'b0, imm_i[4:0], 20'b0};
            end
            IMM_NONE, IMM_NONE_ALT: begin
                mask = '0;
                bits = '0;
            end
        endcase
        insn_o = (tmpl_i & ~mask) | bits;
    end

endmodule

// File: rtl/imm_packer.sv
// Immediate packer: stage 1 checks range/alignment,
// stage 2 packs; errored beats pass the template through.
module imm_packer
    import imm_packer_pkg::*;
#(
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_immSrc,
    input  logic [31:0]         in_imm,
    input  logic [31:0]         in_template,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_insn,
    output logic [1:0]          out_err,
    output logic [ERRCNT_W-1:0] err_count
);

    logic                s1_valid_q, s1_valid_d;
    beat_t               s1_q, s1_d;
    logic                s2_valid_q, s2_valid_d;
    chk_beat_t           s2_q, s2_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        s2_advance;
    imm_err_e    chk_err;
    logic [31:0] packed_insn;

    assign s2_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_advance;

    // Range and alignment check on the stage-1 beat.
    always_comb begin
        chk_err = ERR_OK;
        unique case (s1_q.src)
            IMM_I, IMM_S: begin
                if (!fits_signed(s1_q.imm, 12)) chk_err = ERR_RANGE;
            end
            IMM_B: begin
                if (s1_q.imm[0])                     chk_err = ERR_ALIGN;
                else if (!fits_signed(s1_q.imm, 13)) chk_err = ERR_RANGE;
            end
            IMM_J: begin
                if (s1_q.imm[0])                     chk_err = ERR_ALIGN;
                else if (!fits_signed(s1_q.imm, 21)) chk_err = ERR_RANGE;
            end
            IMM_U: begin
                if (s1_q.imm[11:0] != 12'd0) chk_err = ERR_RANGE;
            end
            IMM_SHAMT: begin
                if (|s1_q.imm[31:5]) chk_err = ERR_RANGE;
            end
            IMM_NONE, IMM_NONE_ALT: chk_err = ERR_OK;
        endcase
    end

    // Pipeline next-state: load on handshake, advance when free.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        err_cnt_d  = err_cnt_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.src  = imm_src_e'(in_immSrc);
                s1_d.imm  = in_imm;
                s1_d.tmpl = in_template;
            end
        end
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.beat = s1_q;
                s2_d.err  = chk_err;
            end
        end
        if (s2_valid_q && out_ready && (s2_q.err != ERR_OK)
            && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    imm_field_pack u_pack (
        .src_i  (s2_q.beat.src),
        .imm_i  (s2_q.beat.imm),
        .tmpl_i (s2_q.beat.tmpl),
        .insn_o (packed_insn)
    );

    assign out_valid = s2_valid_q;
    assign out_err   = s2_q.err;
    assign out_insn  = (s2_q.err != ERR_OK) ? s2_q.beat.tmpl
                                            : packed_insn;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_packer.sv
// Scoreboard bench for imm_packer: driver pushes expected
// beats, a negedge monitor pops and compares.
module tb_imm_packer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_immSrc;
    logic [31:0] in_imm;
    logic [31:0] in_template;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [1:0]  out_err;
    logic [15:0] err_count;

    typedef struct {
        logic [31:0] insn;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    imm_packer #(.ERRCNT_W(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_immSrc   (in_immSrc),
        .in_imm      (in_imm),
        .in_template (in_template),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_insn    (out_insn),
        .out_err     (out_err),
        .err_count   (err_count)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0]  src,
                        input logic [31:0] imm,
                        input logic [31:0] tmpl,
                        input logic [31:0] e_insn,
                        input logic [1:0]  e_err);
        exp_t e;
        in_valid    = 1'b1;
        in_immSrc   = src;
        in_imm      = imm;
        in_template = tmpl;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.insn = e_insn;
                e.err  = e_err;
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL accept_timeout actual=no_ready required=ready");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0) return;
        end
        total++;
        bad++;
        $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    endtask

    // Monitor: compare on each output handshake, check hold on stall.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && out_valid) begin
                if (sb.size() == 0) begin
                    if (out_ready) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat actual=%h required=none",
                                 out_insn);
                    end
                end else if (!out_ready) begin
                    check("stall_hold_insn", out_insn, sb[0].insn);
                end else begin
                    e = sb.pop_front();
                    check("insn", out_insn, e.insn);
                    check("err", {30'b0, out_err}, {30'b0, e.err});
                    check("err_count", {16'b0, err_count}, exp_cnt);
                    if (e.err != 2'b00 && exp_cnt != 16'hFFFF) exp_cnt++;
                end
            end
        end
    end

    initial begin
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_immSrc   = 3'b000;
        in_imm      = '0;
        in_template = '0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_insn", out_insn, 32'h0);
        check("rst_out_err", {30'b0, out_err}, 0);
        check("rst_err_count", {16'b0, err_count}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 1);
        resetn = 1'b1;
        sync();

        // Latency of the first beat
        out_ready = 1'b1;
        send(3'b000, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'b00);
        @(negedge clk);
        check("lat_cycle1_valid", {31'b0, out_valid}, 0);
        @(negedge clk);
        check("lat_cycle2_valid", {31'b0, out_valid}, 1);
        drain();
        sync();

        // Directed vectors, back to back
        send(3'b000, 32'h0000_0005, 32'hABC0_0093, 32'h0050_0093, 2'b00);
        send(3'b000, 32'h0000_0800, 32'h0000_0013, 32'h0000_0013, 2'b01);
        send(3'b000, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 2'b00);
        send(3'b001, 32'hFFFF_FFFC, 32'h0000_2023, 32'hFE00_2E23, 2'b00);
        send(3'b010, 32'd4094,      32'h0000_0063, 32'h7E00_0FE3, 2'b00);
        send(3'b010, 32'd3,         32'h0000_0063, 32'h0000_0063, 2'b10);
        send(3'b010, 32'd4095,      32'h0000_0063, 32'h0000_0063, 2'b10);
        send(3'b010, 32'd4096,      32'h0000_0063, 32'h0000_0063, 2'b01);
        send(3'b010, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 2'b00);
        send(3'b011, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 2'b00);
        send(3'b011, 32'h0010_0000, 32'h0000_006F, 32'h0000_006F, 2'b01);
        send(3'b100, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 2'b00);
        send(3'b100, 32'h1234_5678, 32'h0000_0037, 32'h0000_0037, 2'b01);
        send(3'b101, 32'h0000_0007, 32'h41F0_5013, 32'h4070_5013, 2'b00);
        send(3'b101, 32'h0000_001F, 32'h4000_5013, 32'h41F0_5013, 2'b00);
        send(3'b101, 32'h0000_0020, 32'h4000_5013, 32'h4000_5013, 2'b01);
        send(3'b110, 32'h0001_2345, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00);
        send(3'b111, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b00);
        drain();
        sync();

        // Backpressure: two beats held, intake stalls
        out_ready = 1'b0;
        fork
            begin
                send(3'b000, 32'd1, 32'h13, 32'h0010_0013, 2'b00);
                send(3'b000, 32'd2, 32'h13, 32'h0020_0013, 2'b00);
                send(3'b100, 32'd1, 32'h37, 32'h0000_0037, 2'b01);
                send(3'b000, 32'd4, 32'h13, 32'h0040_0013, 2'b00);
            end
            begin
                repeat (3) @(negedge clk);
                #1;
                check("bp_in_ready", {31'b0, in_ready}, 0);
                check("bp_out_valid", {31'b0, out_valid}, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        sync();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(3'b011, 32'd1, 32'h6F, 32'h0000_006F, 2'b10);
        send(3'b001, 32'hFFFF_0000, 32'h23, 32'h0000_0023, 2'b01);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 0);
        check("mid_rst_err_count", {16'b0, err_count}, 0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 1);
        sb.delete();
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_out_valid", {31'b0, out_valid}, 0);
        sync();
        send(3'b100, 32'hABCD_E000, 32'h0000_00B7, 32'hABCD_E0B7, 2'b00);
        drain();
        check("final_err_count", {16'b0, err_count}, exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
